dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width of data memory.
REQ-002 Parameter DATA_W, default 32, word width.
REQ-003 CLOCK_50  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req0/req1  in  1  access request; port 0 = CPU load/store, port 1 = host loader/readout.
REQ-006 we0/we1  in  1  1 = store word, 0 = load word.
REQ-007 addr0/addr1  in  ADDR_W  byte address, word-aligned.
REQ-008 wdata0/wdata1  in  DATA_W  store data.
REQ-009 gnt0/gnt1  out  1  request accepted this cycle.
REQ-010 rvalid0/rvalid1  out  1  load data valid.
REQ-011 rdata0/rdata1  out  DATA_W  load data, big-endian word {M[a],M[a+1],M[a+2],M[a+3]}.
REQ-012 err0/err1  out  1  one-cycle pulse, misaligned request rejected.
REQ-013 mem_en, mem_we  out  1  memory access strobe and write enable.
REQ-014 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W (1-cycle read latency).
REQ-015 stall_count  out  16  cycles in which any valid request was not granted.

Function
REQ-016 Requester shall hold req, we, addr, wdata stable until gnt; deasserting before gnt is illegal.
REQ-017 At most one grant per cycle; gnt combinational from req and priority pointer.
REQ-018 Single request: granted same cycle.
REQ-019 Both requesting: grant the port not granted most recently (round-robin pointer); pointer updates only on a grant.
REQ-020 Pointer reset value favours port 0.
REQ-021 Aligned grant drives mem_en=1, mem_we=we, mem_addr, mem_wdata in the grant cycle.
REQ-022 Aligned load: rvalidN=1 with rdataN=mem_rdata exactly 1 cycle after gnt; one registered owner bit routes data.
REQ-023 Store: no rvalid; memory written at the grant-cycle edge.
REQ-024 addr[1:0]!=0: gnt asserted, mem_en=0, errN pulses the following cycle, no rvalid; counts as a grant for round-robin.
REQ-025 Back-to-back loads from alternating ports: full throughput, one grant per cycle, rvalid pipelined in order.
REQ-026 rdataN holds last value when rvalidN=0; rdata of the non-owner port shall not change.
REQ-027 stall_count increments by 1 per cycle in which req0&req1 (one loser); saturates at 16'hFFFF.
REQ-028 Load followed next cycle by store to same address from other port: load returns pre-store data.

Reset
REQ-029 rst_n low asynchronously clears pointer, owner bit, rvalid0/1, err0/1, stall_count, rdata0/1 to 0; gnt0/1 and mem_en are 0 while rst_n low.
REQ-030 Reset mid-load cancels the pending rvalid; no response after release.
REQ-031 First grant possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package holds ADDR_W/DATA_W defaults, port index constants (PORT_CPU=0, PORT_HOST=1), stall counter width.
REQ-033 One sub-module rr_arb2: 2-input round-robin grant with pointer register; datapath muxing and response routing stay in dmem_arbiter.

Verification
REQ-034 Reset release, req0 load addr 8'h30, mem holds 32'h0000_0005 -> gnt0 same cycle, rvalid0=1 rdata0=5 next cycle.
REQ-035 req0 and req1 held 4 cycles, both loads -> grants alternate 0,1,0,1; stall_count=4.
REQ-036 req1 store 32'hFFFF_FFF6 to 8'h40, then req0 load 8'h40 -> rdata0=32'hFFFF_FFF6.
REQ-037 req0 load 8'h31 -> gnt0, mem_en=0, err0 pulse next cycle, no rvalid0.
REQ-038 req1 load granted, rst_n low before next edge -> rvalid1 never asserts; all outputs 0.
REQ-039 Both ports requesting continuously 70000 cycles -> stall_count=16'hFFFF.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and helpers for the two-port data-memory arbiter.
package dmem_arbiter_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    localparam int STALL_W    = 16;

    // Port indices: 0 = CPU load/store, 1 = host loader/readout.
    localparam bit PORT_CPU  = 1'b0;
    localparam bit PORT_HOST = 1'b1;

    // A word access is legal only when the two low byte-address bits are zero.
    function automatic logic word_aligned(input logic [1:0] byte_off);
        return byte_off == 2'b00;
    endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, response and memory-side signals for dmem_arbiter.
// slave = arbiter view, master = environment (requesters plus memory).
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              err0, err1;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [STALL_W-1:0] stall_count;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_en, mem_we, mem_addr, mem_wdata, stall_count
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_en, mem_we, mem_addr, mem_wdata, stall_count
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Grant is combinational; the pointer
// remembers which port wins the next tie and moves only on a grant.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic       r_ptr;
    logic [1:0] w_gnt;

    // Grant the lone requester, or the favoured port on a tie; nothing in reset.
    always_comb begin
        // NOTE: default first so every path assigns w_gnt and no latch is inferred.
        w_gnt = 2'b00;
        if (i_rst_n) begin
            if (i_req[0] && i_req[1]) begin
                w_gnt = r_ptr ? 2'b10 : 2'b01;
            end else begin
                w_gnt = i_req;
            end
        end
    end

    assign o_gnt = w_gnt;

    // After a grant, favour the port that was not just served.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking assignments for all clocked state avoid read/write races between processes.
        if (!i_rst_n) begin
            r_ptr <= PORT_CPU;
        end else if (|w_gnt) begin
            r_ptr <= w_gnt[PORT_CPU];
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory with 1-cycle read
// latency. Arbitration lives in rr_arb2; address/data muxing, misalignment
// rejection, load-response routing and the stall counter live here.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input logic            CLOCK_50,
    input logic            rst_n,
    dmem_arbiter_if.slave  bus
);
    logic [1:0]         w_gnt;
    logic               w_sel;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_we;
    logic               w_aligned;
    logic               w_access;
    logic               w_rvalid0, w_rvalid1;

    logic               r_pend;
    logic               r_owner;
    logic               r_err0, r_err1;
    logic [DATA_W-1:0]  r_hold0, r_hold1;
    logic [STALL_W-1:0] r_stall;

    rr_arb2 u_arb (
        .i_clk   (CLOCK_50),
        .i_rst_n (rst_n),
        .i_req   ({bus.req1, bus.req0}),
        .o_gnt   (w_gnt)
    );

    assign w_sel     = w_gnt[PORT_HOST];
    assign w_addr    = w_sel ? bus.addr1  : bus.addr0;
    assign w_wdata   = w_sel ? bus.wdata1 : bus.wdata0;
    assign w_we      = w_sel ? bus.we1    : bus.we0;
    assign w_aligned = word_aligned(w_addr[1:0]);
    // A misaligned grant is accepted but never reaches memory.
    assign w_access  = (|w_gnt) && w_aligned;

    assign bus.gnt0      = w_gnt[PORT_CPU];
    assign bus.gnt1      = w_gnt[PORT_HOST];
    assign bus.mem_en    = w_access;
    assign bus.mem_we    = w_access && w_we;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;

    // Record a pending load response with its owner, and misalignment errors.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= 1'b0;
            r_owner <= PORT_CPU;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            r_pend <= w_access && !w_we;
            if (w_access && !w_we) begin
                r_owner <= w_sel;
            end
            r_err0 <= w_gnt[PORT_CPU]  && !w_aligned;
            r_err1 <= w_gnt[PORT_HOST] && !w_aligned;
        end
    end

    assign w_rvalid0 = r_pend && (r_owner == PORT_CPU);
    assign w_rvalid1 = r_pend && (r_owner == PORT_HOST);

    // Keep each port's last load word so rdata is steady between responses.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        // NOTE: these holding registers are reset because rdata must read 0 out of reset.
        if (!rst_n) begin
            r_hold0 <= '0;
            r_hold1 <= '0;
        end else begin
            if (w_rvalid0) r_hold0 <= bus.mem_rdata;
            if (w_rvalid1) r_hold1 <= bus.mem_rdata;
        end
    end

    assign bus.rvalid0 = w_rvalid0;
    assign bus.rvalid1 = w_rvalid1;
    assign bus.rdata0  = w_rvalid0 ? bus.mem_rdata : r_hold0;
    assign bus.rdata1  = w_rvalid1 ? bus.mem_rdata : r_hold1;
    assign bus.err0    = r_err0;
    assign bus.err1    = r_err1;

    // Count contention cycles (both ports requesting, one loses), saturating.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (bus.req0 && bus.req1 && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign bus.stall_count = r_stall;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: a behavioural memory,
// a reference memory model and an in-order load-response scoreboard.
module tb_dmem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    function automatic logic [DW-1:0] init_word(input int idx);
        return (idx == 12) ? 32'd5 : (32'hC0DE_0000 + DW'(idx));
    endfunction

    // Behavioural memory: written at the grant edge, read data one cycle later.
    logic [DW-1:0] env_mem [64];
    bit            env_wr  [64];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                env_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
                env_wr[bus.mem_addr[7:2]]  <= 1'b1;
            end else begin
                bus.mem_rdata <= env_wr[bus.mem_addr[7:2]] ? env_mem[bus.mem_addr[7:2]]
                                                           : init_word(int'(bus.mem_addr[7:2]));
            end
        end
    end

    // Reference model, updated only by the stimulus process.
    logic [DW-1:0] ref_mem [64];
    bit            ref_wr  [64];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_wr[a[7:2]] ? ref_mem[a[7:2]] : init_word(int'(a[7:2]));
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on every response; rdata must not move without rvalid.
    logic [DW-1:0] prev0 = '0, prev1 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.rvalid0 || bus.rvalid1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rvalid_port", {30'd0, bus.rvalid1, bus.rvalid0}, e.port ? 32'd2 : 32'd1);
                    check("rdata", e.port ? bus.rdata1 : bus.rdata0, e.data);
                end
            end
            if (!bus.rvalid0) check("rdata0_hold", bus.rdata0, prev0);
            if (!bus.rvalid1) check("rdata1_hold", bus.rdata1, prev1);
        end
        prev0 = bus.rdata0;
        prev1 = bus.rdata1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic set1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    endtask

    task automatic push(input logic port, input logic [AW-1:0] a);
        sb_q.push_back('{port: port, data: ref_rd(a)});
    endtask

    task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ref_mem[a[7:2]] = d;
        ref_wr[a[7:2]]  = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) tick();
        check(tag, DW'(sb_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},    {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check({tag, "_mem_en"}, {31'd0, bus.mem_en}, 32'd0);
        check({tag, "_rvalid"}, {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
        check({tag, "_err"},    {30'd0, bus.err1, bus.err0}, 32'd0);
        check({tag, "_stall"},  {16'd0, bus.stall_count}, 32'd0);
        check({tag, "_rdata0"}, bus.rdata0, 32'd0);
        check({tag, "_rdata1"}, bus.rdata1, 32'd0);
    endtask

    task automatic do_reset();
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic          prio;
        logic [AW-1:0] a0, a1;

        // Reset: outputs idle even with a request pending.
        set0(1'b1, 1'b0, 8'h30, '0);
        set1(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        check_all_zero("reset");

        // First edge after release grants the CPU load of 8'h30.
        rst_n = 1'b1;
        #1;
        check("t034_gnt0", {31'd0, bus.gnt0}, 32'd1);
        check("t034_gnt1", {31'd0, bus.gnt1}, 32'd0);
        check("t034_mem_en", {31'd0, bus.mem_en}, 32'd1);
        check("t034_mem_addr", {24'd0, bus.mem_addr}, 32'h30);
        push(1'b0, 8'h30);
        tick();
        set0(1'b0, 1'b0, '0, '0);
        check("t034_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
        check("t034_rdata0", bus.rdata0, 32'd5);
        drain("t034_drain");

        // Contention for 4 cycles from a fresh pointer: grants 0,1,0,1.
        do_reset();
        a0 = 8'h00;
        a1 = 8'h08;
        for (int k = 0; k < 4; k++) begin
            set0(1'b1, 1'b0, a0, '0);
            set1(1'b1, 1'b0, a1, '0);
            #1;
            check("t035_stall", {16'd0, bus.stall_count}, DW'(k));
            check("t035_gnt0", {31'd0, bus.gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t035_gnt1", {31'd0, bus.gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 0) push(1'b0, a0); else push(1'b1, a1);
            tick();
            if (k % 2 == 0) a0 = a0 + 8'd4; else a1 = a1 + 8'd4;
        end
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        #1;
        check("t035_stall_final", {16'd0, bus.stall_count}, 32'd4);
        drain("t035_drain");

        // Host store then CPU load of the same word.
        set1(1'b1, 1'b1, 8'h40, 32'hFFFF_FFF6);
        #1;
        check("t036_gnt1", {31'd0, bus.gnt1}, 32'd1);
        check("t036_mem_we", {31'd0, bus.mem_we}, 32'd1);
        check("t036_mem_wdata", bus.mem_wdata, 32'hFFFF_FFF6);
        ref_write(8'h40, 32'hFFFF_FFF6);
        tick();
        set1(1'b0, 1'b0, '0, '0);
        set0(1'b1, 1'b0, 8'h40, '0);
        #1;
        check("t036_gnt0", {31'd0, bus.gnt0}, 32'd1);
        push(1'b0, 8'h40);
        tick();
        set0(1'b0, 1'b0, '0, '0);
        drain("t036_drain");

        // Load followed by a store to the same word returns pre-store data.
        set0(1'b1, 1'b0, 8'h44, '0);
        #1;
        check("t028_load_gnt0", {31'd0, bus.gnt0}, 32'd1);
        push(1'b0, 8'h44);
        tick();
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b1, 1'b1, 8'h44, 32'hA5A5_0044);
        #1;
        check("t028_store_gnt1", {31'd0, bus.gnt1}, 32'd1);
        ref_write(8'h44, 32'hA5A5_0044);
        tick();
        set1(1'b0, 1'b0, '0, '0);
        set0(1'b1, 1'b0, 8'h44, '0);
        #1;
        push(1'b0, 8'h44);
        tick();
        set0(1'b0, 1'b0, '0, '0);
        drain("t028_drain");

        // Misaligned CPU load after a host grant: rejected, but it takes the turn.
        set1(1'b1, 1'b0, 8'h08, '0);
        #1;
        push(1'b1, 8'h08);
        tick();
        set1(1'b0, 1'b0, '0, '0);
        set0(1'b1, 1'b0, 8'h31, '0);
        #1;
        check("t037_gnt0", {31'd0, bus.gnt0}, 32'd1);
        check("t037_mem_en", {31'd0, bus.mem_en}, 32'd0);
        tick();
        set0(1'b1, 1'b0, 8'h00, '0);
        set1(1'b1, 1'b0, 8'h04, '0);
        #1;
        check("t037_err0", {31'd0, bus.err0}, 32'd1);
        check("t037_err1", {31'd0, bus.err1}, 32'd0);
        check("t037_rvalid0", {31'd0, bus.rvalid0}, 32'd0);
        check("t037_rr_gnt1", {31'd0, bus.gnt1}, 32'd1);
        push(1'b1, 8'h04);
        tick();
        set1(1'b0, 1'b0, '0, '0);
        #1;
        check("t037_err0_pulse", {31'd0, bus.err0}, 32'd0);
        check("t037_rr_gnt0", {31'd0, bus.gnt0}, 32'd1);
        push(1'b0, 8'h00);
        tick();
        set0(1'b0, 1'b0, '0, '0);
        drain("t037_drain");

        // Misaligned host store: rejected, memory untouched, err1 pulses.
        set1(1'b1, 1'b1, 8'h43, 32'h1234_5678);
        #1;
        check("t037h_gnt1", {31'd0, bus.gnt1}, 32'd1);
        check("t037h_mem_en", {31'd0, bus.mem_en}, 32'd0);
        tick();
        set1(1'b0, 1'b0, '0, '0);
        set0(1'b1, 1'b0, 8'h40, '0);
        #1;
        check("t037h_err1", {31'd0, bus.err1}, 32'd1);
        check("t037h_err0", {31'd0, bus.err0}, 32'd0);
        push(1'b0, 8'h40);
        tick();
        set0(1'b0, 1'b0, '0, '0);
        drain("t037h_drain");

        // Reset during the grant cycle of a host load: no response ever.
        set1(1'b1, 1'b0, 8'h0C, '0);
        #1;
        check("t038_gnt1", {31'd0, bus.gnt1}, 32'd1);
        rst_n = 1'b0;
        set1(1'b0, 1'b0, '0, '0);
        #1;
        check_all_zero("t038_in_reset");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t038_rvalid1", {31'd0, bus.rvalid1}, 32'd0);
        end

        // Reset right after a load was accepted cancels the pending response.
        set1(1'b1, 1'b0, 8'h0C, '0);
        #1;
        tick();
        set1(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        check_all_zero("t030_in_reset");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t030_rvalid1", {31'd0, bus.rvalid1}, 32'd0);
        end

        // Continuous contention: alternating full-throughput grants, saturation.
        do_reset();
        prio = 1'b0;
        set0(1'b1, 1'b0, 8'h00, '0);
        set1(1'b1, 1'b0, 8'h04, '0);
        for (int i = 0; i < 70000; i++) begin
            #1;
            check("t039_stall", {16'd0, bus.stall_count}, (i >= 65535) ? 32'h0000_FFFF : DW'(i));
            check("t039_gnt0", {31'd0, bus.gnt0}, prio ? 32'd0 : 32'd1);
            check("t039_gnt1", {31'd0, bus.gnt1}, prio ? 32'd1 : 32'd0);
            push(prio, prio ? 8'h04 : 8'h00);
            prio = ~prio;
            tick();
        end
        #1;
        check("t039_stall_sat", {16'd0, bus.stall_count}, 32'h0000_FFFF);
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        drain("t039_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
